fpu_uart_cmd_sequencer: RTL and testbench
=========================================

// Module: fpu_uart_cmd_sequencer
// PURPOSE
//  Sequences the single-precision FPU from a UART byte stream. Assembles a 9-byte command
//  frame (opcode byte + operand A + operand B) from the UART receiver. Issues one start
//  pulse to the FPU datapath and waits for done, bounded by a timeout. Latches the result
//  and exception flags that drive the FPU_sp_result pads/LA bus.
// PARAMETERS
//  CNT_W        20          width of gap/timeout counters
//  GAP_CYC      20'd50000   max idle clocks between bytes of one frame before frame is discarded
//  FPU_TIMEOUT  20'd4096    max clocks in WAIT for fpu_done before abort
// PORTS
//  clk           in   1   system clock (LA-muxed wb_clk_i)
//  rst_l         in   1   asynchronous active-low reset
//  rx_valid      in   1   1-cycle strobe: rx_data holds a received UART byte
//  rx_data       in   8   received byte
//  fpu_op        out  5   FPU operation select, held stable from ISSUE until next frame
//  fpu_rm        out  3   rounding mode, held like fpu_op
//  fpu_opa       out  32  operand A
//  fpu_opb       out  32  operand B
//  fpu_start     out  1   1-cycle start pulse to FPU
//  fpu_done      in   1   FPU completion strobe, sampled only in WAIT
//  fpu_result    in   32  FPU result, valid with fpu_done
//  fpu_flags     in   5   {NV,DZ,OF,UF,NX}, valid with fpu_done
//  FPU_sp_result out  32  registered last good result
//  flags         out  5   registered flags of last good result
//  result_valid  out  1   1-cycle pulse when FPU_sp_result/flags update
//  busy          out  1   high in ISSUE and WAIT
//  err_timeout   out  1   sticky; set on FPU timeout, cleared by first byte of next frame
//  err_overrun   out  1   sticky; set when a byte arrives while busy, cleared like err_timeout
// BEHAVIOUR
//  - Reset (async, rst_l=0): all outputs and registers 0, state IDLE, byte index 0.
//  - Frame: byte0={rm[2:0],op[4:0]}; bytes1-4 = opa LSB first; bytes5-8 = opb LSB first.
//  - States: IDLE -> COLLECT -> ISSUE -> WAIT -> IDLE.
//    IDLE: rx_valid stores byte0, clears err_*, idx=1, loads gap counter, goes to COLLECT.
//    COLLECT: each rx_valid writes byte idx into opa/opb, idx++, reloads gap counter.
//      Byte 8 accepted -> ISSUE. Gap counter reaching 0 -> IDLE, partial frame discarded.
//      No error flag is set. rx_valid in the same cycle as gap expiry: byte wins.
//    ISSUE: fpu_start=1 for exactly one cycle; fpu_op/rm/opa/opb already stable. Next state WAIT.
//      Timeout counter loads FPU_TIMEOUT.
//    WAIT: fpu_done=1 -> capture fpu_result/fpu_flags into FPU_sp_result/flags, and
//      result_valid=1 on the next cycle; state returns to IDLE. Counter reaching 0 -> err_timeout=1,
//      IDLE, no result update, no result_valid. fpu_done in the same cycle as counter=0: done wins.
//  - rx_valid during ISSUE/WAIT: byte dropped, err_overrun=1. The frame in flight is unaffected.
//  - Latency: last byte at cycle T -> fpu_start at T+1 -> WAIT from T+2. fpu_done at D ->
//    outputs updated and result_valid at D+1, busy=0 at D+1. A new byte0 is accepted at D+1.
//  - fpu_done outside WAIT is ignored. FPU_sp_result holds its value across frames,
//    timeouts and gap aborts. It changes only on reset or a good completion.
//  - Operand/opcode registers are written only in IDLE/COLLECT, never while busy.
//  - Reset mid-operation: immediate return to IDLE with all outputs 0. fpu_start is never
//    glitched high.
// TESTING
//  1 Bytes 00,00,00,80,3F,00,00,00,40 (add, 1.0+2.0); fpu_done after 10 cycles with 40400000 ->
//    fpu_opa=3F800000, fpu_opb=40000000, one fpu_start pulse, FPU_sp_result=40400000,
//    one result_valid, flags=0.
//  2 Five frame bytes, then GAP_CYC+1 idle cycles, then a full 9-byte frame ->
//    only one fpu_start, and it uses the second frame's operands.
//  3 Full frame and fpu_done never asserted -> err_timeout=1 exactly FPU_TIMEOUT+2 cycles
//    after fpu_start. FPU_sp_result unchanged, no result_valid. Next byte0 clears err_timeout.
//  4 Byte arrives during WAIT -> err_overrun=1, opa/opb unchanged. Result from fpu_done is
//    still latched.
//  5 fpu_done on the same cycle the timeout counter reaches 0 -> result latched, err_timeout=0.
//  6 rst_l low for 1 cycle during WAIT -> all outputs 0 immediately. A later fpu_done is ignored.
//    A following frame runs normally.

Source files
------------

// File: rtl/fpu_uart_cmd_sequencer.sv
// UART command sequencer for the single-precision FPU: assembles a 9-byte frame,
// fires one start pulse, waits for done under a timeout and latches the result.
module fpu_uart_cmd_sequencer #(
    parameter int             CNT_W       = 20,
    parameter logic [CNT_W-1:0] GAP_CYC     = 20'd50000,
    parameter logic [CNT_W-1:0] FPU_TIMEOUT = 20'd4096
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic [31:0] fpu_opa,
    output logic [31:0] fpu_opb,
    output logic        fpu_start,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    output logic [31:0] FPU_sp_result,
    output logic [4:0]  flags,
    output logic        result_valid,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2,
        WAIT    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [4:0]       op_q, op_d;
    logic [2:0]       rm_q, rm_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic             start_q, start_d;
    logic [31:0]      res_q, res_d;
    logic [4:0]       flags_q, flags_d;
    logic             rv_q, rv_d;
    logic             err_to_q, err_to_d;
    logic             err_ov_q, err_ov_d;
    logic [2:0]       lane;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            gap_q    <= '0;
            tmo_q    <= '0;
            op_q     <= '0;
            rm_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            start_q  <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
            rv_q     <= 1'b0;
            err_to_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            tmo_q    <= tmo_d;
            op_q     <= op_d;
            rm_q     <= rm_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            start_q  <= start_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            rv_q     <= rv_d;
            err_to_q <= err_to_d;
            err_ov_q <= err_ov_d;
        end
    end

    // Bytes 1-4 and 5-8 map onto the same four byte lanes of opa/opb.
    assign lane = idx_q[2:0] - 3'd1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        tmo_d    = tmo_q;
        op_d     = op_q;
        rm_d     = rm_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        start_d  = 1'b0;
        res_d    = res_q;
        flags_d  = flags_q;
        rv_d     = 1'b0;
        err_to_d = err_to_q;
        err_ov_d = err_ov_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    op_d     = rx_data[4:0];
                    rm_d     = rx_data[7:5];
                    err_to_d = 1'b0;
                    err_ov_d = 1'b0;
                    idx_d    = 4'd1;
                    gap_d    = GAP_CYC;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    if (lane[2])
                        opb_d[{lane[1:0], 3'b000} +: 8] = rx_data;
                    else
                        opa_d[{lane[1:0], 3'b000} +: 8] = rx_data;
                    gap_d = GAP_CYC;
                    if (idx_q == 4'd8) begin
                        idx_d   = 4'd0;
                        start_d = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else if (gap_q == '0) begin
                    idx_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            ISSUE: begin
                if (rx_valid) err_ov_d = 1'b1;
                tmo_d   = FPU_TIMEOUT;
                state_d = WAIT;
            end
            WAIT: begin
                if (rx_valid) err_ov_d = 1'b1;
                // A done arriving on the last timeout cycle still counts as a good result.
                if (fpu_done) begin
                    res_d   = fpu_result;
                    flags_d = fpu_flags;
                    rv_d    = 1'b1;
                    state_d = IDLE;
                end else if (tmo_q == '0) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fpu_op        = op_q;
    assign fpu_rm        = rm_q;
    assign fpu_opa       = opa_q;
    assign fpu_opb       = opb_q;
    assign fpu_start     = start_q;
    assign FPU_sp_result = res_q;
    assign flags         = flags_q;
    assign result_valid  = rv_q;
    assign busy          = (state_q == ISSUE) || (state_q == WAIT);
    assign err_timeout   = err_to_q;
    assign err_overrun   = err_ov_q;

endmodule

// File: tb/tb_fpu_uart_cmd_sequencer.sv
// Scoreboard bench for fpu_uart_cmd_sequencer: expected issues/results are queued by
// the stimulus and popped by a monitor whenever fpu_start or result_valid fires.
module tb_fpu_uart_cmd_sequencer;

    localparam logic [19:0] GAP = 20'd200;
    localparam logic [19:0] TMO = 20'd100;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [4:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_opa;
    logic [31:0] fpu_opb;
    logic        fpu_start;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_result = 32'h0;
    logic [4:0]  fpu_flags = 5'h0;
    logic [31:0] FPU_sp_result;
    logic [4:0]  flags;
    logic        result_valid;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    logic prev_start = 1'b0;

    logic [71:0] exp_start_q[$];
    logic [36:0] exp_res_q[$];

    fpu_uart_cmd_sequencer #(
        .CNT_W(20), .GAP_CYC(GAP), .FPU_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_l(rst_l), .rx_valid(rx_valid), .rx_data(rx_data),
        .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
        .fpu_start(fpu_start), .fpu_done(fpu_done), .fpu_result(fpu_result),
        .fpu_flags(fpu_flags), .FPU_sp_result(FPU_sp_result), .flags(flags),
        .result_valid(result_valid), .busy(busy), .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares each issue and each result against the queued expectation.
    always @(negedge clk) begin
        if (rst_l) begin
            if (fpu_start) begin
                start_cnt++;
                chk("start_single_cycle", {71'd0, prev_start}, 72'd0);
                if (exp_start_q.size() == 0)
                    chk("unexpected_start", 72'd1, 72'd0);
                else
                    chk("issue_operands", {fpu_op, fpu_rm, fpu_opa, fpu_opb}, exp_start_q.pop_front());
            end
            if (result_valid) begin
                if (exp_res_q.size() == 0)
                    chk("unexpected_result_valid", 72'd1, 72'd0);
                else
                    chk("result", {35'd0, FPU_sp_result, flags}, {35'd0, exp_res_q.pop_front()});
            end
        end
        prev_start <= fpu_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_ops(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [31:0] a, input logic [31:0] b);
        exp_start_q.push_back({b0[4:0], b0[7:5], a, b});
        send_byte(b0);
        send_ops(a, b);
    endtask

    task automatic wait_start(output int c);
        int n;
        n = 0;
        while (!fpu_start && n < 20) begin
            tick();
            n++;
        end
        c = cyc;
        chk("start_seen", {71'd0, fpu_start}, 72'd1);
        chk("busy_in_issue", {71'd0, busy}, 72'd1);
    endtask

    task automatic pulse_done(input int dly, input logic [31:0] r, input logic [4:0] f, input bit good);
        repeat (dly) tick();
        fpu_done   = 1'b1;
        fpu_result = r;
        fpu_flags  = f;
        if (good) exp_res_q.push_back({r, f});
        tick();
        fpu_done = 1'b0;
    endtask

    initial begin
        int c0;
        int c1;
        int n;
        // Reset state
        #2;
        chk("reset_outputs", {33'd0, fpu_start, busy, result_valid, err_timeout, err_overrun,
                              FPU_sp_result}, 72'd0);
        chk("reset_operands", {3'd0, fpu_op, fpu_rm, fpu_opa, fpu_opb}, 72'd0);
        tick();
        tick();
        rst_l = 1'b1;
        tick();

        // 1: 1.0 + 2.0
        send_frame(8'h00, 32'h3F800000, 32'h40000000);
        wait_start(c0);
        chk("t1_opa", {40'd0, fpu_opa}, {40'd0, 32'h3F800000});
        chk("t1_opb", {40'd0, fpu_opb}, {40'd0, 32'h40000000});
        pulse_done(10, 32'h40400000, 5'h00, 1'b1);
        chk("t1_rv_and_idle", {70'd0, result_valid, busy}, 72'd2);
        chk("t1_result", {35'd0, FPU_sp_result, flags}, {35'd0, 32'h40400000, 5'h00});
        tick();

        // 2: partial frame dropped by gap timeout, then a full frame
        n = start_cnt;
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (int'(GAP) + 1) tick();
        chk("t2_no_start_partial", start_cnt, n);
        send_frame(8'h22, 32'hC0A00000, 32'h3F000000);
        wait_start(c0);
        pulse_done(3, 32'hC1200000, 5'h01, 1'b1);
        chk("t2_one_start", start_cnt, n + 1);
        chk("t2_err_clear", {70'd0, err_timeout, err_overrun}, 72'd0);
        tick();

        // 3: no done -> timeout at start + TMO + 2
        send_frame(8'h41, 32'h12345678, 32'h9ABCDEF0);
        wait_start(c0);
        n = 0;
        while (!err_timeout && n < 2 * int'(TMO)) begin
            tick();
            n++;
        end
        c1 = cyc;
        chk("t3_timeout_set", {71'd0, err_timeout}, 72'd1);
        chk("t3_timeout_cycle", c1 - c0, int'(TMO) + 2);
        chk("t3_idle_after_timeout", {71'd0, busy}, 72'd0);
        chk("t3_result_held", {35'd0, FPU_sp_result, flags}, {35'd0, 32'hC1200000, 5'h01});

        // 4: byte0 clears timeout; overrun byte during WAIT
        exp_start_q.push_back({5'h03, 3'h0, 32'h40490FDB, 32'h402DF854});
        send_byte(8'h03);
        chk("t4_byte0_clears_timeout", {71'd0, err_timeout}, 72'd0);
        send_ops(32'h40490FDB, 32'h402DF854);
        wait_start(c0);
        tick();
        send_byte(8'hAA);
        chk("t4_overrun", {71'd0, err_overrun}, 72'd1);
        chk("t4_ops_unchanged", {8'd0, fpu_opa, fpu_opb}, {8'd0, 32'h40490FDB, 32'h402DF854});
        chk("t4_still_busy", {71'd0, busy}, 72'd1);
        pulse_done(2, 32'h40C90FDB, 5'h01, 1'b1);
        chk("t4_result", {35'd0, FPU_sp_result, flags}, {35'd0, 32'h40C90FDB, 5'h01});
        chk("t4_overrun_sticky", {71'd0, err_overrun}, 72'd1);
        tick();

        // 5: done on the cycle the timeout counter hits zero
        send_frame(8'h64, 32'h7F7FFFFF, 32'h7F7FFFFF);
        chk("t5_overrun_cleared", {71'd0, err_overrun}, 72'd0);
        wait_start(c0);
        pulse_done(int'(TMO) + 1, 32'h7F800000, 5'h05, 1'b1);
        chk("t5_no_timeout", {71'd0, err_timeout}, 72'd0);
        chk("t5_result", {35'd0, FPU_sp_result, flags}, {35'd0, 32'h7F800000, 5'h05});
        tick();

        // 6: reset during WAIT
        send_frame(8'h01, 32'h00000001, 32'h00000002);
        wait_start(c0);
        tick();
        tick();
        rst_l = 1'b0;
        #1;
        chk("t6_reset_outputs", {33'd0, fpu_start, busy, result_valid, err_timeout, err_overrun,
                                 FPU_sp_result}, 72'd0);
        chk("t6_reset_operands", {3'd0, fpu_op, fpu_rm, fpu_opa, fpu_opb, flags == 5'd0}, 72'd1);
        tick();
        rst_l = 1'b1;
        tick();
        pulse_done(0, 32'hDEADBEEF, 5'h1F, 1'b0);
        tick();
        chk("t6_late_done_ignored", {35'd0, FPU_sp_result, flags}, 72'd0);
        send_frame(8'h00, 32'h3F800000, 32'h40000000);
        wait_start(c0);
        pulse_done(4, 32'h40400000, 5'h00, 1'b1);
        chk("t6_after_reset_result", {35'd0, FPU_sp_result, flags}, {35'd0, 32'h40400000, 5'h00});
        tick();
        tick();

        chk("pending_starts", exp_start_q.size(), 0);
        chk("pending_results", exp_res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
